time_adjust_ctrl: RTL and testbench
===================================

TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, meaning CLOCK_50 cycles per 1 Hz time tick.
REQ-002 SHALL have parameter BLINK_DIV, default 12500000, meaning CLOCK_50 cycles per blink-phase toggle.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; the block's only clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port adjust  input  1  high = run mode, low = adjust mode; level, synchronous to CLOCK_50.
REQ-006 SHALL have port add  input  1  increment request; acted on at its rising edge only.
REQ-007 SHALL have port clr  input  1  clear request; acted on at its rising edge only.
REQ-008 SHALL have port select  input  4  field select; select[1:0]: 0 = seconds, 1 = minutes, 2 = hours, 3 = none; select[3:2] ignored.
REQ-009 SHALL have port sec  output  6  seconds, binary 0..59.
REQ-010 SHALL have port min  output  6  minutes, binary 0..59.
REQ-011 SHALL have port hour  output  5  hours, binary 0..23.
REQ-012 SHALL have port tick_1hz  output  1  one-cycle pulse on each run-mode time tick.
REQ-013 SHALL have port day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-014 SHALL have port blank  output  3  display-blank flags; bit0 = sec, bit1 = min, bit2 = hour.

Function
REQ-015 SHALL implement a two-state FSM, RUN and ADJ; RUN -> ADJ when adjust = 0, ADJ -> RUN when adjust = 1, evaluated every cycle.
REQ-016 SHALL, in RUN, count a prescaler 0..CLK_DIV-1 and assert tick_1hz for the single cycle in which the prescaler wraps to 0.
REQ-017 SHALL, on each tick, increment sec, with carry sec 59 -> 0 into min, min 59 -> 0 into hour, and hour 23 -> 0 asserting day_pulse in that same cycle.
REQ-018 SHALL, in ADJ, hold the prescaler at 0 and generate no tick_1hz and no day_pulse.
REQ-019 SHALL, on the ADJ -> RUN transition, restart the prescaler from 0 so that the first tick occurs CLK_DIV cycles after the transition.
REQ-020 SHALL detect rising edges of add and clr with one register each; an edge is current = 1 and previous = 0.
REQ-021 SHALL, in ADJ, on an add edge increment only the selected field, wrapping 59 -> 0 (sec, min) or 23 -> 0 (hour), with no carry into another field.
REQ-022 SHALL, in ADJ, on a clr edge set only the selected field to 0.
REQ-023 SHALL, when add and clr edges occur in the same cycle, apply clr and ignore add.
REQ-024 SHALL ignore add and clr edges in RUN, and in ADJ when select[1:0] = 3.
REQ-025 SHALL update the target field in the cycle after the detected edge (one-cycle latency).
REQ-026 SHALL, in ADJ, run a blink counter 0..BLINK_DIV-1 that toggles a blink phase on each wrap; blank[i] = blink phase AND field i selected; blank = 0 in RUN.
REQ-027 SHALL clear the blink counter and blink phase on the RUN -> ADJ transition, so the selected field is first shown unblanked for BLINK_DIV cycles.
REQ-028 SHALL, when adjust falls in the same cycle as a prescaler wrap, enter ADJ without applying that tick.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force: FSM = RUN; sec = min = hour = 0; prescaler = 0; blink counter = 0; blink phase = 0; tick_1hz = day_pulse = 0; blank = 0.
REQ-030 SHALL reset the add and clr edge registers to 1, so that a button already held at reset release produces no edge.
REQ-031 SHALL, when rst_n is asserted mid-adjust or mid-count, abandon all pending work; the first edge after rst_n rises is processed normally.

Verification
REQ-032 SHALL cover: CLK_DIV = 4, RUN from reset -> tick_1hz every 4th cycle, sec = 1 after the first tick.
REQ-033 SHALL cover: preload 23:59:59, one tick -> 00:00:00 with day_pulse high for exactly 1 cycle.
REQ-034 SHALL cover: ADJ, select = 1, min = 59, add pulse -> min = 0, hour unchanged, no tick during ADJ.
REQ-035 SHALL cover: ADJ, select = 2, add and clr rising in the same cycle, hour = 5 -> hour = 0.
REQ-036 SHALL cover: BLINK_DIV = 2, ADJ, select = 0 -> blank = 000 for 2 cycles, then 001 for 2 cycles, alternating; select = 3 -> blank = 000.
REQ-037 SHALL cover: add held high across rst_n release -> no field change; add asserted mid-ADJ, then rst_n low -> all fields 0 and FSM = RUN.

Source files
------------

// File: rtl/time_adjust_ctrl.sv
// Time-of-day counter (hh:mm:ss) with a run/adjust mode FSM.
// Adjust mode edits one field from button edges and blinks it.
`timescale 1ns/1ps
module time_adjust_ctrl #(
   parameter int CLK_DIV   = 50000000,
   parameter int BLINK_DIV = 12500000
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       adjust,
   input  logic       add,
   input  logic       clr,
   input  logic [3:0] select,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       tick_1hz,
   output logic       day_pulse,
   output logic [2:0] blank
);

   typedef enum logic {RUN, ADJ} state_t;

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          tick_q, tick_d;
   logic          day_q, day_d;
   logic          add_prev_q, add_prev_d;
   logic          clr_prev_q, clr_prev_d;

   logic          add_edge, clr_edge;
   logic [2:0]    sel_mask;
   logic          sel_unused;

   assign sel_unused = ^select[3:2];

   assign add_edge = add & ~add_prev_q;
   assign clr_edge = clr & ~clr_prev_q;

   always_comb begin
      sel_mask = 3'b000;
      unique case (select[1:0])
         2'd0: sel_mask = 3'b001;
         2'd1: sel_mask = 3'b010;
         2'd2: sel_mask = 3'b100;
         default: sel_mask = 3'b000;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hour_d      = hour_q;
      tick_d      = 1'b0;
      day_d       = 1'b0;
      add_prev_d  = add;
      clr_prev_d  = clr;

      unique case (state_q)
         RUN: begin
            if (!adjust) begin
               // a wrap coinciding with the mode change is dropped
               state_d     = ADJ;
               presc_d     = '0;
               blink_cnt_d = '0;
               phase_d     = 1'b0;
            end else if (presc_q == PRE_MAX) begin
               presc_d = '0;
               tick_d  = 1'b1;
               if (sec_q == 6'd59) begin
                  sec_d = '0;
                  if (min_q == 6'd59) begin
                     min_d = '0;
                     if (hour_q == 5'd23) begin
                        hour_d = '0;
                        day_d  = 1'b1;
                     end else begin
                        hour_d = hour_q + 5'd1;
                     end
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         ADJ: begin
            presc_d = '0;
            if (adjust) state_d = RUN;
            if (blink_cnt_q == BLK_MAX) begin
               blink_cnt_d = '0;
               phase_d     = ~phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
            if (clr_edge) begin
               if (sel_mask[0]) sec_d  = '0;
               if (sel_mask[1]) min_d  = '0;
               if (sel_mask[2]) hour_d = '0;
            end else if (add_edge) begin
               if (sel_mask[0])
                  sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
               if (sel_mask[1])
                  min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
               if (sel_mask[2])
                  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         presc_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         sec_q       <= '0;
         min_q       <= '0;
         hour_q      <= '0;
         tick_q      <= 1'b0;
         day_q       <= 1'b0;
         // held buttons at release must not look like a fresh press
         add_prev_q  <= 1'b1;
         clr_prev_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hour_q      <= hour_d;
         tick_q      <= tick_d;
         day_q       <= day_d;
         add_prev_q  <= add_prev_d;
         clr_prev_q  <= clr_prev_d;
      end
   end

   assign sec       = sec_q;
   assign min       = min_q;
   assign hour      = hour_q;
   assign tick_1hz  = tick_q;
   assign day_pulse = day_q;
   assign blank     = (state_q == ADJ && phase_q) ? sel_mask : 3'b000;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed self-checking bench for time_adjust_ctrl
// (CLK_DIV = 4, BLINK_DIV = 2).
`timescale 1ns/1ps
module tb_time_adjust_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       adjust = 1'b1;
   logic       add = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] select = 4'd0;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       tick_1hz;
   logic       day_pulse;
   logic [2:0] blank;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int tick_seen = 0;

   time_adjust_ctrl #(.CLK_DIV(4), .BLINK_DIV(2)) dut (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .adjust   (adjust),
      .add      (add),
      .clr      (clr),
      .select   (select),
      .sec      (sec),
      .min      (min),
      .hour     (hour),
      .tick_1hz (tick_1hz),
      .day_pulse(day_pulse),
      .blank    (blank)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (tick_1hz === 1'b1) tick_seen++;

   task automatic do_reset(input logic adj);
      rst_n = 1'b0;
      adjust = adj;
      add = 1'b0;
      clr = 1'b0;
      select = 4'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_add(input int n);
      repeat (n) begin
         @(posedge clk); #1 add = 1'b1;
         @(posedge clk); #1 add = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      adjust = 1'b0;
      add = 1'b1;
      clr = 1'b0;
      select = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if ({sec, min, hour} !== 17'd0) $display("FAIL reset_fields got %0d:%0d:%0d want 0:0:0", hour, min, sec);
      else pass_cnt++;
      chk_cnt++;
      if ({tick_1hz, day_pulse, blank} !== 5'd0) $display("FAIL reset_pulses got tick=%b day=%b blank=%b want 0 0 000", tick_1hz, day_pulse, blank);
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk_cnt++;
      if (sec !== 6'd0) $display("FAIL held_add_release got sec=%0d want 0", sec);
      else pass_cnt++;
      add = 1'b0;
      pulse_add(1);
      chk_cnt++;
      if (sec !== 6'd1) $display("FAIL first_edge_after_reset got sec=%0d want 1", sec);
      else pass_cnt++;
   endtask

   task automatic test_tick();
      logic exp;
      do_reset(1'b1);
      for (int i = 0; i <= 12; i++) begin
         @(negedge clk);
         exp = (i > 0) && (i % 4 == 0);
         chk_cnt++;
         if (tick_1hz !== exp) $display("FAIL tick_period cyc=%0d got %b want %b", i, tick_1hz, exp);
         else pass_cnt++;
         if (i == 4) begin
            chk_cnt++;
            if (sec !== 6'd1) $display("FAIL sec_first_tick got %0d want 1", sec);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (sec !== 6'd3) $display("FAIL sec_after_3_ticks got %0d want 3", sec);
      else pass_cnt++;
   endtask

   task automatic test_adj_min();
      int t0;
      do_reset(1'b0);
      t0 = tick_seen;
      select = 4'd1;
      pulse_add(59);
      chk_cnt++;
      if (min !== 6'd59) $display("FAIL min_preload got %0d want 59", min);
      else pass_cnt++;
      @(posedge clk); #1 add = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (min !== 6'd59) $display("FAIL add_latency got min=%0d want 59", min);
      else pass_cnt++;
      @(posedge clk); #1 add = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({hour, min, sec} !== 17'd0) $display("FAIL min_wrap got %0d:%0d:%0d want 0:0:0", hour, min, sec);
      else pass_cnt++;
      chk_cnt++;
      if (tick_seen !== t0) $display("FAIL no_tick_in_adj got %0d ticks want 0", tick_seen - t0);
      else pass_cnt++;
   endtask

   task automatic test_rollover();
      logic exp;
      do_reset(1'b0);
      select = 4'd2; pulse_add(23);
      select = 4'd1; pulse_add(59);
      select = 4'd0; pulse_add(59);
      chk_cnt++;
      if (hour !== 5'd23 || min !== 6'd59 || sec !== 6'd59)
         $display("FAIL preload_235959 got %0d:%0d:%0d want 23:59:59", hour, min, sec);
      else pass_cnt++;
      @(posedge clk); #1 adjust = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         exp = (i == 5);
         chk_cnt++;
         if (day_pulse !== exp || tick_1hz !== exp)
            $display("FAIL day_pulse cyc=%0d got day=%b tick=%b want %b", i, day_pulse, tick_1hz, exp);
         else pass_cnt++;
         if (i == 4) begin
            chk_cnt++;
            if (hour !== 5'd23) $display("FAIL pre_rollover got hour=%0d want 23", hour);
            else pass_cnt++;
         end
         if (i == 5) begin
            chk_cnt++;
            if ({hour, min, sec} !== 17'd0) $display("FAIL rollover got %0d:%0d:%0d want 0:0:0", hour, min, sec);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_wrap_drop();
      int t0;
      do_reset(1'b1);
      t0 = tick_seen;
      repeat (3) @(posedge clk);
      #1 adjust = 1'b0;
      repeat (4) @(negedge clk);
      chk_cnt++;
      if (sec !== 6'd0 || tick_seen !== t0)
         $display("FAIL wrap_on_adjust_fall got sec=%0d ticks=%0d want 0 0", sec, tick_seen - t0);
      else pass_cnt++;
   endtask

   task automatic test_clr();
      do_reset(1'b0);
      select = 4'd2;
      pulse_add(5);
      chk_cnt++;
      if (hour !== 5'd5) $display("FAIL hour_preload got %0d want 5", hour);
      else pass_cnt++;
      @(posedge clk); #1 add = 1'b1; clr = 1'b1;
      @(posedge clk); #1 add = 1'b0; clr = 1'b0;
      chk_cnt++;
      if (hour !== 5'd0) $display("FAIL clr_over_add got hour=%0d want 0", hour);
      else pass_cnt++;
      select = 4'd0; pulse_add(3);
      select = 4'd1; pulse_add(2);
      select = 4'd0; pulse_clr();
      chk_cnt++;
      if (sec !== 6'd0 || min !== 6'd2) $display("FAIL clr_sec_only got min=%0d sec=%0d want 2 0", min, sec);
      else pass_cnt++;
   endtask

   task automatic test_ignore();
      do_reset(1'b0);
      select = 4'd1; pulse_add(2);
      select = 4'd3; pulse_add(2); pulse_clr();
      chk_cnt++;
      if ({hour, min, sec} !== {5'd0, 6'd2, 6'd0})
         $display("FAIL select_none got %0d:%0d:%0d want 0:2:0", hour, min, sec);
      else pass_cnt++;
      select = 4'b0110;
      pulse_add(24);
      chk_cnt++;
      if (hour !== 5'd0 || min !== 6'd2) $display("FAIL hour_wrap got hour=%0d min=%0d want 0 2", hour, min);
      else pass_cnt++;
      do_reset(1'b1);
      select = 4'd1;
      pulse_add(3);
      chk_cnt++;
      if (min !== 6'd0) $display("FAIL add_in_run got min=%0d want 0", min);
      else pass_cnt++;
   endtask

   task automatic test_blink();
      logic [2:0] exp;
      do_reset(1'b1);
      select = 4'd0;
      @(posedge clk); #1 adjust = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         exp = ((i >= 1) && (((i - 1) / 2) % 2 == 1)) ? 3'b001 : 3'b000;
         chk_cnt++;
         if (blank !== exp) $display("FAIL blink cyc=%0d got %b want %b", i, blank, exp);
         else pass_cnt++;
      end
      select = 4'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (blank !== 3'b000) $display("FAIL blink_none cyc=%0d got %b want 000", i, blank);
         else pass_cnt++;
      end
      select = 4'd2;
      @(posedge clk); #1 adjust = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (blank !== 3'b000) $display("FAIL blank_in_run got %b want 000", blank);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic exp;
      do_reset(1'b0);
      select = 4'd0; pulse_add(2);
      select = 4'd1; pulse_add(1);
      @(posedge clk); #1 add = 1'b1;
      #2 rst_n = 1'b0;
      adjust = 1'b1;
      add = 1'b0;
      #1;
      chk_cnt++;
      if ({hour, min, sec} !== 17'd0 || blank !== 3'b000)
         $display("FAIL async_reset got %0d:%0d:%0d blank=%b want 0:0:0 000", hour, min, sec, blank);
      else pass_cnt++;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         exp = (i == 4);
         chk_cnt++;
         if (tick_1hz !== exp) $display("FAIL run_after_reset cyc=%0d got %b want %b", i, tick_1hz, exp);
         else pass_cnt++;
      end
      chk_cnt++;
      if (sec !== 6'd1 || min !== 6'd0) $display("FAIL fields_after_reset got min=%0d sec=%0d want 0 1", min, sec);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_tick();
      test_adj_min();
      test_rollover();
      test_wrap_drop();
      test_clr();
      test_ignore();
      test_blink();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
